pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
Program-counter stage directly upstream of the instruction-fetch path. It holds the current PC and computes the next PC by selecting among sequential (PC+4), branch target (PC+offset) and jump target through a 2:1 select chain. It issues each PC to instruction memory over a valid/ready handshake and counts accepted fetches.

Parameters:
WIDTH, 32, datapath width of PC, offset and targets
RESET_PC, 32'h0000_0000, PC value loaded on reset
INC, 4, sequential increment in bytes

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC; the fetch handshake does not complete while high
fetch_ready  in  1  instruction memory accepts the current PC
branch  in  1  conditional branch in decode
zero  in  1  ALU zero flag qualifying the branch
jump  in  1  unconditional jump
imm  in  WIDTH  signed branch byte offset, relative to current PC
jtarget  in  WIDTH  absolute jump target
halt  in  1  stop fetching after the current handshake
pc  out  WIDTH  current PC, registered
pc_plus  out  WIDTH  pc + INC, combinational from pc
fetch_valid  out  1  pc is a valid fetch request
fetch_count  out  WIDTH  accepted fetches, saturating
err  out  1  misaligned target detected (see Optional Feature)

Behaviour:
- Reset (async, any time including mid-handshake): pc=RESET_PC, fetch_valid=0, fetch_count=0, err=0, state=IDLE. pc_plus reads RESET_PC+INC.
- States:
  - IDLE: fetch_valid=0. Moves to ISSUE unconditionally on the first clk edge after rst deasserts.
  - ISSUE: fetch_valid=1.
  - HALTED: fetch_valid=0; pc and fetch_count frozen; only rst exits.
- Handshake: accept = fetch_valid & fetch_ready & ~stall. pc is stable while fetch_valid=1 and accept=0. Holding fetch_ready high with stall high causes no advance.
- On accept:
  - pc <= next_pc.
  - fetch_count <= fetch_count+1, saturating at all-ones (no wrap).
  - If halt=1, state goes to HALTED and pc still loads next_pc. halt without accept is ignored.
- next_pc priority:
  - jump=1: jtarget.
  - else branch & zero: pc + imm.
  - else: pc + INC.
- Arithmetic is modulo 2^WIDTH; wrap-around is silent (e.g. pc=FFFF_FFFC with INC → 0000_0000).
- branch, zero, jump, imm and jtarget are sampled only in the accept cycle.
- Latency: next_pc is visible on pc one cycle after the accept edge. Sustained throughput is one fetch per cycle with ready=1 and stall=0.
- Simultaneous jump and branch&zero: jump wins.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: an accepted next_pc with bits[1:0]≠0 forces pc <= next_pc with bits[1:0] cleared, sets err=1 (sticky until rst), and moves to HALTED.
- Undefined: no check; next_pc loads unmodified and err is tied 0.

Decomposition:
- Package pc_pkg: state encoding (IDLE, ISSUE, HALTED), INC default, select encoding for the next-PC source (SEQ, BR, JMP).
- One sub-module, next_pc_sel: purely combinational; two cascaded WIDTH-bit 2:1 selects plus two adders. It takes pc, imm, jtarget, branch, zero, jump and outputs next_pc. The top keeps the FSM, registers and counter.

Test Plan:
1. Reset then ready=1, stall=0, no branch/jump for 4 cycles → pc goes 0,4,8,C,10; fetch_count=4; fetch_valid is 0 in the first cycle after reset.
2. pc=0x10, branch=1, zero=1, imm=0xFFFF_FFF8 at accept → pc=0x08. Same with zero=0 → pc=0x14.
3. jump=1, jtarget=0x100, branch=1, zero=1 in the same accept → pc=0x100 (jump priority).
4. ready=1 with stall=1 for 3 cycles, then stall=0 → pc unchanged and fetch_valid=1 throughout the stall; advances by 4 on release; count increments once.
5. halt=1 with ready=0, then ready=1 → first cycle no effect; next cycle pc advances, state HALTED, fetch_valid=0, pc frozen over 5 more cycles. rst asserted mid-run → immediate pc=0, count=0.
6. With PC_ALIGN_CHECK_EN, jump to 0x102 → pc=0x100, err=1, HALTED. Without the macro → pc=0x102, err=0.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// Shared encodings for the PC stage: FSM states, default increment and next-PC source select.
package pc_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam int INC_DEFAULT = 4;

   typedef enum logic [1:0] {
      SEL_SEQ = 2'd0,
      SEL_BR  = 2'd1,
      SEL_JMP = 2'd2
   } pc_sel_e;

endpackage

// File: rtl/pc_next_unit_if.sv
// Fetch request bus between the PC stage (master) and instruction memory (slave).
interface pc_next_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus;
   logic             fetch_valid;
   logic             fetch_ready;

   modport master (
      output pc,
      output pc_plus,
      output fetch_valid,
      input  fetch_ready
   );

   modport slave (
      input  pc,
      input  pc_plus,
      input  fetch_valid,
      output fetch_ready
   );
endinterface

// File: rtl/pc_next_unit_next_pc_sel.sv
// Combinational next-PC select: sequential vs branch, then that result vs jump target.
module next_pc_sel
   import pc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int INC   = INC_DEFAULT
) (
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] jtarget,
   input  logic             branch,
   input  logic             zero,
   input  logic             jump,
   output logic [WIDTH-1:0] next_pc
);

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   logic [WIDTH-1:0] seq_target;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] br_or_seq;
   pc_sel_e          sel;

   assign seq_target = pc + INC_W;
   assign br_target  = pc + imm;

   // Jump outranks a taken branch.
   assign sel = jump            ? SEL_JMP :
                (branch & zero) ? SEL_BR  : SEL_SEQ;

   assign br_or_seq = (sel == SEL_BR)  ? br_target : seq_target;
   assign next_pc   = (sel == SEL_JMP) ? jtarget   : br_or_seq;

endmodule

// File: rtl/pc_next_unit.sv
// PC stage: holds the PC, issues it over a valid/ready fetch handshake and counts accepted fetches.
// Optional alignment trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_next_unit
   import pc_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
   parameter int               INC      = INC_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch,
   input  logic             zero,
   input  logic             jump,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] jtarget,
   input  logic             halt,
   output logic [WIDTH-1:0] fetch_count,
   output logic             err,
   pc_next_unit_if.master   fetch
);

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] pc_reg, pc_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [WIDTH-1:0] sel_pc;
   logic [WIDTH-1:0] load_pc;
   logic             accept;
   logic             misaligned;

   next_pc_sel #(
      .WIDTH (WIDTH),
      .INC   (INC)
   ) u_sel (
      .pc      (pc_reg),
      .imm     (imm),
      .jtarget (jtarget),
      .branch  (branch),
      .zero    (zero),
      .jump    (jump),
      .next_pc (sel_pc)
   );

`ifdef PC_ALIGN_CHECK_EN
   assign misaligned = |sel_pc[1:0];
   assign load_pc    = {sel_pc[WIDTH-1:2], 2'b00};
`else
   assign misaligned = 1'b0;
   assign load_pc    = sel_pc;
`endif

   assign fetch.fetch_valid = (state_reg == ST_ISSUE);
   assign fetch.pc          = pc_reg;
   assign fetch.pc_plus     = pc_reg + INC_W;
   assign fetch_count       = count_reg;

   assign accept = fetch.fetch_valid & fetch.fetch_ready & ~stall;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      count_next = count_reg;
      case (state_reg)
         ST_IDLE: state_next = ST_ISSUE;
         ST_ISSUE: begin
            if (accept) begin
               pc_next    = load_pc;
               count_next = (&count_reg) ? count_reg : count_reg + WIDTH'(1);
               if (halt || misaligned)
                  state_next = ST_HALTED;
            end
         end
         ST_HALTED: state_next = ST_HALTED;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         pc_reg    <= RESET_PC;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         count_reg <= count_next;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic err_reg;

   // Sticky until reset; only a misaligned target that is actually accepted trips it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_reg <= 1'b0;
      else if (accept && misaligned)
         err_reg <= 1'b1;
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: sequential fetch, branch, jump priority, stall, halt, reset, wrap, alignment.
module tb_pc_next_unit;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall;
   logic             branch;
   logic             zero;
   logic             jump;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] jtarget;
   logic             halt;
   logic [WIDTH-1:0] fetch_count;
   logic             err;

   int checks = 0;
   int errors = 0;

   pc_next_unit_if #(.WIDTH(WIDTH)) fif ();

   pc_next_unit #(
      .WIDTH    (WIDTH),
      .RESET_PC (32'h0000_0000),
      .INC      (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .branch      (branch),
      .zero        (zero),
      .jump        (jump),
      .imm         (imm),
      .jtarget     (jtarget),
      .halt        (halt),
      .fetch_count (fetch_count),
      .err         (err),
      .fetch       (fif.master)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-14s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_state(input string tag, input logic [WIDTH-1:0] e_pc,
                              input logic e_valid, input logic [WIDTH-1:0] e_cnt);
      check({tag, ".pc"},    fif.pc,                  e_pc);
      check({tag, ".valid"}, {31'd0, fif.fetch_valid}, {31'd0, e_valid});
      check({tag, ".count"}, fetch_count,             e_cnt);
   endtask

   task automatic clear_ctl();
      branch  = 1'b0;
      zero    = 1'b0;
      jump    = 1'b0;
      imm     = '0;
      jtarget = '0;
      halt    = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      fif.fetch_ready = 1'b0;
      clear_ctl();
      step();
      step();

      // Reset state
      check_state("rst", 32'h0, 1'b0, 32'd0);
      check("rst.pc_plus", fif.pc_plus, 32'h4);
      check("rst.err", {31'd0, err}, 32'd0);

      // First cycle after reset release is IDLE
      rst = 1'b0;
      fif.fetch_ready = 1'b1;
      #1;
      check("idle.valid", {31'd0, fif.fetch_valid}, 32'd0);
      step();
      check_state("issue", 32'h0, 1'b1, 32'd0);

      // Sequential fetch, one per cycle
      step(); check_state("seq1", 32'h4, 1'b1, 32'd1);
      step(); check_state("seq2", 32'h8, 1'b1, 32'd2);
      step(); check_state("seq3", 32'hC, 1'b1, 32'd3);
      step(); check_state("seq4", 32'h10, 1'b1, 32'd4);

      // Taken branch backwards by 8
      branch = 1'b1; zero = 1'b1; imm = 32'hFFFF_FFF8;
      step(); check_state("br_taken", 32'h08, 1'b1, 32'd5);

      // Branch with zero=0 falls through
      zero = 1'b0;
      step(); check_state("br_not", 32'h0C, 1'b1, 32'd6);

      // Jump beats taken branch
      zero = 1'b1; jump = 1'b1; jtarget = 32'h100;
      step(); check_state("jmp_prio", 32'h100, 1'b1, 32'd7);
      clear_ctl();

      // Stall with ready high: no advance
      stall = 1'b1;
      step(); check_state("stall1", 32'h100, 1'b1, 32'd7);
      step(); check_state("stall2", 32'h100, 1'b1, 32'd7);
      step(); check_state("stall3", 32'h100, 1'b1, 32'd7);
      stall = 1'b0;
      step(); check_state("unstall", 32'h104, 1'b1, 32'd8);

      // halt without accept is ignored
      fif.fetch_ready = 1'b0; halt = 1'b1;
      step(); check_state("halt_noacc", 32'h104, 1'b1, 32'd8);
      fif.fetch_ready = 1'b1;
      step(); check_state("halt_acc", 32'h108, 1'b0, 32'd9);
      halt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_state("halted", 32'h108, 1'b0, 32'd9);
      end

      // Asynchronous reset mid-cycle
      rst = 1'b1;
      #1;
      check_state("async_rst", 32'h0, 1'b0, 32'd0);
      step();
      rst = 1'b0;
      step(); check_state("re_issue", 32'h0, 1'b1, 32'd0);

      // Wrap-around at top of address space
      jump = 1'b1; jtarget = 32'hFFFF_FFFC;
      step(); check_state("jmp_top", 32'hFFFF_FFFC, 1'b1, 32'd1);
      check("top.pc_plus", fif.pc_plus, 32'h0);
      clear_ctl();
      step(); check_state("wrap", 32'h0, 1'b1, 32'd2);

      // Misaligned jump target
      jump = 1'b1; jtarget = 32'h102;
      step();
`ifdef PC_ALIGN_CHECK_EN
      check_state("misalign", 32'h100, 1'b0, 32'd3);
      check("misalign.err", {31'd0, err}, 32'd1);
      clear_ctl();
      step();
      check_state("mis_frozen", 32'h100, 1'b0, 32'd3);
      check("mis_sticky", {31'd0, err}, 32'd1);
`else
      check_state("misalign", 32'h102, 1'b1, 32'd3);
      check("misalign.err", {31'd0, err}, 32'd0);
      clear_ctl();
      step();
      check_state("after_mis", 32'h106, 1'b1, 32'd4);
      check("err_low", {31'd0, err}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
